// File: rtl/mult_share_ctrl.sv
// Round-robin controller sharing one sequential multiplier among NREQ requesters.
// Latency: accept edge to resp_valid is 3 + k cycles, k = WAIT cycles until mul_valid (k <= TIMEOUT).
// Backpressure: req_ready is granted only in IDLE; requesters hold req_valid until accepted.
module mult_share_ctrl #(
  parameter int N       = 4,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*N-1:0]   req_a,
  input  logic [NREQ*N-1:0]   req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic [NREQ-1:0]     resp_valid,
  output logic [2*N-1:0]      resp_p,
  output logic                resp_err,
  output logic                busy,
  output logic                mul_load,
  output logic [N-1:0]        mul_a,
  output logic [N-1:0]        mul_b,
  input  logic [2*N-1:0]      mul_p,
  input  logic                mul_valid
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, WAIT, RESP} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   grant;
  logic [CW-1:0]   cnt;
  logic            found;
  logic [PW-1:0]   pick;

  // (base + off) mod NREQ, used for the scan order and the pointer advance
  function automatic logic [PW-1:0] rr_add(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s[PW-1:0];
  endfunction

  // Scan requesters starting at ptr; first active one wins
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req_valid[rr_add(ptr, j)]) begin
        found = 1'b1;
        pick  = rr_add(ptr, j);
      end
    end
  end

  // Accept strobe only while idle, so a grant never overlaps a transaction
  always_comb begin
    req_ready = '0;
    if (state == IDLE && found) req_ready[pick] = 1'b1;
  end

  assign busy = (state != IDLE);

  // Transaction FSM: grant, load pulse, ignore one stale cycle, wait with timeout, respond
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      grant      <= '0;
      cnt        <= '0;
      resp_valid <= '0;
      resp_p     <= '0;
      resp_err   <= 1'b0;
      mul_load   <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
    end else begin
      mul_load   <= 1'b0;
      resp_valid <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            mul_a    <= req_a[int'(pick)*N +: N];
            mul_b    <= req_b[int'(pick)*N +: N];
            grant    <= pick;
            mul_load <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: state <= SETTLE;
        SETTLE: begin
          // mul_valid may still be high from the previous product here
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (mul_valid) begin
            resp_p     <= mul_p;
            resp_err   <= 1'b0;
            resp_valid <= NREQ'(1) << grant;
            state      <= RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            resp_p     <= '0;
            resp_err   <= 1'b1;
            resp_valid <= NREQ'(1) << grant;
            state      <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          ptr   <= rr_add(grant, 1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: directed scenarios plus random contention against a
// round-robin reference model and a behavioural multiplier with selectable latency.
module tb_mult_share_ctrl;
  localparam int N = 4, NREQ = 4, TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_a, req_b;
  logic [3:0]  req_ready, resp_valid;
  logic [7:0]  resp_p;
  logic        resp_err, busy, mul_load;
  logic [3:0]  mul_a, mul_b;
  logic [7:0]  mul_p;
  logic        mul_valid;

  int tests = 0;
  int fails = 0;

  // multiplier environment: 0 = behavioural multiplier, 1 = never valid, 2 = hand driven
  int          mode = 0;
  int          mlat = 2;
  int          mcnt = 0;
  logic        auto_valid = 1'b0;
  logic [7:0]  auto_p = 8'd0;
  logic        man_valid = 1'b0;
  logic [7:0]  man_p = 8'd0;

  // requester model
  logic [3:0] want = 4'b0;
  logic [3:0] pa [4];
  logic [3:0] pb [4];
  int         rptr = 0;

  mult_share_ctrl #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_p(resp_p), .resp_err(resp_err), .busy(busy),
    .mul_load(mul_load), .mul_a(mul_a), .mul_b(mul_b),
    .mul_p(mul_p), .mul_valid(mul_valid)
  );

  always #5 clk = ~clk;

  assign mul_valid = (mode == 0) ? auto_valid : (mode == 1) ? 1'b0 : man_valid;
  assign mul_p     = (mode == 0) ? auto_p     : (mode == 1) ? 8'hA5 : man_p;

  // Behavioural multiplier: valid rises mlat cycles after load and stays high until the next load
  always @(negedge clk) begin
    if (!rst_n) begin
      auto_valid <= 1'b0;
      mcnt       <= 0;
    end else if (mul_load) begin
      auto_valid <= 1'b0;
      auto_p     <= 8'(mul_a) * 8'(mul_b);
      mcnt       <= mlat;
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) auto_valid <= 1'b1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    req_valid = want;
    for (int i = 0; i < 4; i++) begin
      req_a[i*4 +: 4] = pa[i];
      req_b[i*4 +: 4] = pb[i];
    end
  endtask

  function automatic int rr_pick(input logic [3:0] w, input int p);
    for (int j = 0; j < 4; j++)
      if (w[(p + j) % 4]) return (p + j) % 4;
    return -1;
  endfunction

  // hand-driven multiplier profile: stale valid in LOAD/SETTLE, low two cycles, then 45
  task automatic man_step(input int n);
    if (mode == 2) begin
      if (n <= 2) begin man_valid = 1'b1; man_p = 8'd99; end
      else if (n <= 4) man_valid = 1'b0;
      else begin man_valid = 1'b1; man_p = 8'd45; end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    want = 4'b0;
    drive();
    rptr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // One transaction: k = expected WAIT cycles, err = expect timeout response
  task automatic txn(input int k, input bit err, input bit persist, output int g);
    int n, c;
    logic [7:0] exp_p;
    logic [3:0] ea, eb;
    drive();
    #1;
    c = 0;
    while (req_ready == 4'b0 && c < 40) begin
      @(negedge clk); #1; c++;
    end
    if (req_ready == 4'b0) begin
      chk("accept_wait", 32'(req_ready), 32'hF);
      g = -1;
      return;
    end
    g = rr_pick(want, rptr);
    chk("grant", 32'(req_ready), 32'(1) << g);
    chk("idle_busy", 32'(busy), 32'd0);
    ea = pa[g];
    eb = pb[g];
    exp_p = err ? 8'd0 : 8'(ea) * 8'(eb);
    @(negedge clk);
    n = 1;
    if (!persist) want[g] = 1'b0;
    else begin pa[g] = 4'($urandom); pb[g] = 4'($urandom); end
    drive();
    man_step(n);
    #1;
    chk("load_pulse", 32'(mul_load), 32'd1);
    chk("no_ready_busy", 32'(req_ready), 32'd0);
    chk("mul_ab", {24'd0, mul_a, mul_b}, {24'd0, ea, eb});
    while (resp_valid == 4'b0 && n < 40) begin
      @(negedge clk);
      n++;
      man_step(n);
      #1;
      if (n == 2) chk("load_single", 32'(mul_load), 32'd0);
    end
    chk("latency", n, 3 + k);
    chk("resp_valid", 32'(resp_valid), 32'(1) << g);
    chk("resp_p", 32'(resp_p), 32'(exp_p));
    chk("resp_err", 32'(resp_err), 32'(err));
    rptr = (g + 1) % 4;
    @(negedge clk); #1;
    chk("resp_pulse", 32'(resp_valid), 32'd0);
    chk("resp_hold", {23'd0, resp_err, resp_p}, {23'd0, err, exp_p});
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int g, prev;
    for (int i = 0; i < 4; i++) begin pa[i] = '0; pb[i] = '0; end
    rst_n = 1'b0;
    drive();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp", {23'd0, resp_err, resp_p}, 32'd0);
    chk("rst_busy_load", {30'd0, busy, mul_load}, 32'd0);
    chk("rst_mul_ab", {24'd0, mul_a, mul_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // single requester
    pa[0] = 4'd2; pb[0] = 4'd4; want = 4'b0001; mlat = 2;
    txn(1, 1'b0, 1'b0, g);
    chk("single_grant", g, 0);

    // contention from a fresh pointer
    do_reset();
    pa[0] = 4'd3;  pb[0] = 4'd15;
    pa[1] = 4'd15; pb[1] = 4'd15;
    pa[2] = 4'd1;  pb[2] = 4'd1;
    pa[3] = 4'd0;  pb[3] = 4'd9;
    want = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      mlat = $urandom_range(2, 6);
      txn(mlat - 1, 1'b0, 1'b0, g);
      chk("contention_order", g, i);
    end

    // fairness between two persistent requesters
    pa[0] = 4'($urandom); pb[0] = 4'($urandom);
    pa[2] = 4'($urandom); pb[2] = 4'($urandom);
    want = 4'b0101;
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      mlat = $urandom_range(2, 5);
      txn(mlat - 1, 1'b0, 1'b1, g);
      chk("fair_alternate", g, (i % 2) * 2);
      chk("fair_no_repeat", 32'(g == prev), 32'd0);
      prev = g;
    end
    want = 4'b0;
    drive();

    // timeout then normal recovery
    mode = 1;
    pa[1] = 4'd5; pb[1] = 4'd5; want = 4'b0010;
    txn(TIMEOUT, 1'b1, 1'b0, g);
    chk("timeout_grant", g, 1);
    mode = 0;
    pa[2] = 4'd7; pb[2] = 4'd3; want = 4'b0100; mlat = 3;
    txn(2, 1'b0, 1'b0, g);

    // stale valid through LOAD and SETTLE
    mode = 2; man_valid = 1'b1; man_p = 8'd99;
    pa[2] = 4'd5; pb[2] = 4'd9; want = 4'b0100;
    txn(3, 1'b0, 1'b0, g);
    mode = 0;

    // random contention
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 4; i++) begin
        if (!want[i] && $urandom_range(0, 1) == 1) begin
          want[i] = 1'b1;
          pa[i] = 4'($urandom);
          pb[i] = 4'($urandom);
        end
      end
      if (want == 4'b0) begin
        want[0] = 1'b1; pa[0] = 4'hF; pb[0] = 4'($urandom);
      end
      mlat = $urandom_range(2, 7);
      txn(mlat - 1, 1'b0, 1'b0, g);
    end
    want = 4'b0;
    drive();

    // reset in WAIT: park pointer at 3 first so the reset pointer is visible
    pa[2] = 4'd1; pb[2] = 4'd1; want = 4'b0100; mlat = 2;
    txn(1, 1'b0, 1'b0, g);
    mode = 1;
    pa[3] = 4'd6; pb[3] = 4'd7; want = 4'b1000;
    drive();
    #1;
    chk("abort_grant", 32'(req_ready), 32'h8);
    @(negedge clk);
    want = 4'b0;
    drive();
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_resp", {19'd0, resp_valid, resp_err, resp_p}, 32'd0);
    chk("abort_busy_load", {30'd0, busy, mul_load}, 32'd0);
    chk("abort_mul_ab", {24'd0, mul_a, mul_b}, 32'd0);
    want = 4'b1010;
    drive();
    #1;
    chk("abort_ptr_scan", 32'(req_ready), 32'h2);
    want = 4'b0;
    drive();
    mode = 0;
    repeat (3) begin
      @(negedge clk); #1;
      chk("abort_no_resp", 32'(resp_valid), 32'd0);
    end
    rst_n = 1'b1;
    rptr = 0;
    pa[3] = 4'd6; pb[3] = 4'd7; want = 4'b1000; mlat = 2;
    txn(1, 1'b0, 1'b0, g);
    chk("post_reset_grant", g, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
Round-robin controller that shares one sequential multiplier (load/a/b in, p/valid out) among NREQ requesters. It accepts one operand pair per transaction and drives a one-cycle load pulse into the multiplier. It then waits for the multiplier's valid, guarded by a timeout, and returns the 2N-bit product to the granted requester. It sits between client blocks and the single multiplier instance.

Parameters:
N, 4, operand width; product width is 2*N
NREQ, 4, number of requesters (2..8)
TIMEOUT, 16, maximum WAIT cycles before an error response (>=N+2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request strobe
req_a  in  NREQ*N  packed operand A; requester i occupies [i*N +: N]
req_b  in  NREQ*N  packed operand B; same packing
req_ready  out  NREQ  one-hot accept, combinational
resp_valid  out  NREQ  one-hot registered response pulse
resp_p  out  2*N  product of last response, held until the next response
resp_err  out  1  set with resp_valid when the timeout expired
busy  out  1  high in any state except IDLE
mul_load  out  1  load pulse to the multiplier
mul_a  out  N  operand A to the multiplier
mul_b  out  N  operand B to the multiplier
mul_p  in  2*N  multiplier product
mul_valid  in  1  multiplier result-valid

Behaviour:
- Reset (async, rst_n=0) forces: state=IDLE, rr pointer=0, grant=0, resp_valid=0, resp_p=0, resp_err=0, mul_load=0, mul_a=0, mul_b=0, timeout counter=0. Reset can occur in any state and aborts the transaction with no response.
- FSM states: IDLE, LOAD, SETTLE, WAIT, RESP.
- IDLE:
  - grant g is the first i with req_valid[i]=1, scanning ptr, ptr+1, ... mod NREQ.
  - req_ready[g]=1 in the same cycle. The handshake completes there.
  - At the clock edge: latch req_a/req_b slice g into mul_a/mul_b; store g; go to LOAD.
  - req_ready=0 in all other states and when no req_valid is set.
- LOAD: mul_load=1 for exactly this one cycle; next state SETTLE.
- SETTLE: one cycle. mul_valid is ignored because it can still be stale-high from the previous operation. Clear the counter; next state WAIT.
- WAIT:
  - If mul_valid=1: capture mul_p into resp_p, clear resp_err, go to RESP.
  - Else: increment the counter. When the counter reaches TIMEOUT-1 with no mul_valid: resp_p=0, resp_err=1, go to RESP.
  - mul_valid in the same cycle as the last count wins; the response is normal, not an error.
- RESP:
  - resp_valid[g]=1 for exactly one cycle.
  - ptr <= (g+1) mod NREQ.
  - Next state IDLE. No new grant is issued in this cycle.
- mul_a and mul_b hold stable from LOAD through RESP.
- Requests raised outside IDLE are not lost if they are held; req_valid must stay high until req_ready.
- Throughput: at most one transaction per (4 + multiplier latency) cycles.
- Simultaneous requests are granted in round-robin order, so no requester starves while the others are persistent.
- Latency: req accept edge to resp_valid = 3 + k cycles, where k is the number of WAIT cycles until mul_valid.
- Products are unsigned. resp_p is exactly the multiplier's 2N bits, with no truncation.
- resp_p and resp_err persist after the resp_valid pulse until the next RESP.

Test Plan:
1. Single requester: rst_n pulse low, then req 0 with a=2, b=4 and a reference multiplier attached -> one-cycle req_ready[0]; one-cycle mul_load; resp_valid=0001, resp_p=8, resp_err=0; busy low afterwards.
2. Contention: reqs 0..3 all valid with (3,15), (15,15), (1,1), (0,9) -> grants in order 0,1,2,3; resp_p=45, 225, 1, 0; each resp_valid one-hot matches its grant.
3. Round-robin fairness: req 0 and req 2 held valid continuously -> grants alternate 0,2,0,2 over 4 transactions; never the same requester twice in a row.
4. Timeout: stub mul_valid=0 with TIMEOUT=16, req 1 with (5,5) -> resp_valid=0010 exactly 3+16 cycles after accept; resp_err=1, resp_p=0. A following request completes normally with resp_err=0.
5. Stale valid: mul_valid stuck high through LOAD and SETTLE, then low, then high with p=45 -> the stale valid is ignored; resp_p=45.
6. Reset mid-WAIT: assert rst_n=0 during WAIT -> all outputs 0 immediately; no resp_valid. After release, req 3 is served as the first grant with ptr=0 scan order.
